// File: rtl/lx32_arch_pkg.sv
// LX32 architectural constants and shared types for the register file and
// its pending-write scoreboard.
package lx32_arch_pkg;
  localparam int XLEN           = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int NUM_RD_DEFAULT = 2;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]           data_t;
  typedef logic [REG_COUNT-1:0]      pend_vec_t;
  typedef logic [REG_ADDR_WIDTH:0]   pend_cnt_t;
endpackage

// File: rtl/lx32_scoreboard.sv
// Per-register pending-write tracker. Flush beats issue, issue beats a
// same-register writeback; the pending count is kept incrementally.
module lx32_scoreboard
  import lx32_arch_pkg::*;
#(
  parameter int REG_COUNT = lx32_arch_pkg::REG_COUNT,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_en_i,
  input  logic [AW-1:0]        issue_addr_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic                 flush_i,
  output logic [REG_COUNT-1:0] pend_o,
  output logic [AW:0]          pend_cnt_o
);

  logic [REG_COUNT-1:0] pend_q, pend_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 set_hit, clr_hit, inc, dec;

  assign set_hit = issue_en_i && (issue_addr_i != '0);
  // A same-cycle issue to the writeback target is a newer producer, so the
  // writeback must not clear its mark.
  assign clr_hit = wr_en_i && (wr_addr_i != '0) &&
                   !(set_hit && (issue_addr_i == wr_addr_i));

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (flush_i) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (set_hit) begin
        pend_d[issue_addr_i] = 1'b1;
        inc = !pend_q[issue_addr_i];
      end
      if (clr_hit) begin
        pend_d[wr_addr_i] = 1'b0;
        dec = pend_q[wr_addr_i];
      end
      cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/lx32_regfile_sb.sv
// LX32 register file: NUM_RD combinational read ports, optional write-to-read
// bypass and optional pending-write scoreboard. x0 is hardwired to zero.
module lx32_regfile_sb
  import lx32_arch_pkg::*;
#(
  parameter int XLEN       = lx32_arch_pkg::XLEN,
  parameter int REG_COUNT  = lx32_arch_pkg::REG_COUNT,
  parameter int NUM_RD     = lx32_arch_pkg::NUM_RD_DEFAULT,
  parameter int BYPASS     = 1,
  parameter int SCOREBOARD = 1,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic                   issue_en_i,
  input  logic [AW-1:0]          issue_addr_i,
  input  logic                   flush_i,
  output logic [AW:0]            pend_cnt_o
);

  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  generate
    if (SCOREBOARD != 0) begin : g_sb
      lx32_scoreboard #(.REG_COUNT(REG_COUNT)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_en_i  (issue_en_i),
        .issue_addr_i(issue_addr_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .flush_i     (flush_i),
        .pend_o      (pend),
        .pend_cnt_o  (pend_cnt_o)
      );
    end else begin : g_no_sb
      assign pend       = '0;
      assign pend_cnt_o = '0;
    end
  endgenerate

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = rd_addr_i[k*AW +: AW];
      // Forwarding is suppressed under reset so outputs drop to zero at once.
      assign hit  = (BYPASS != 0) && !rst && wr_en_i &&
                    (wr_addr_i == addr) && (addr != '0);
      assign rd_data_o[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         hit ? wr_data_i : regs_q[addr];
      assign rd_busy_o[k] = (addr != '0) && pend[addr] && !hit;
    end
  endgenerate

endmodule

// File: tb/tb_lx32_regfile_sb.sv
// Scoreboard bench for lx32_regfile_sb (defaults: 32x32, 2 ports, bypass on).
module tb_lx32_regfile_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        issue_en_i;
  logic [4:0]  issue_addr_i;
  logic        flush_i;
  logic [5:0]  pend_cnt_o;

  lx32_regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_busy_o   (rd_busy_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .issue_en_i  (issue_en_i),
    .issue_addr_i(issue_addr_i),
    .flush_i     (flush_i),
    .pend_cnt_o  (pend_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: architectural registers and a set of pending registers.
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  function automatic int pend_count();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_pend[i] ? 1 : 0;
    return s;
  endfunction

  function automatic logic [31:0] exp_read(bit r, bit we, int wa, logic [31:0] wd, int a);
    if (r || a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(bit r, bit we, int wa, int a);
    if (r || a == 0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic cycle(input bit r, input bit we, input int wa, input logic [31:0] wd,
                       input bit ie, input int ia, input bit fl, input int a0, input int a1);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    wr_en_i      = we;
    wr_addr_i    = 5'(wa);
    wr_data_i    = wd;
    issue_en_i   = ie;
    issue_addr_i = 5'(ia);
    flush_i      = fl;
    rd_addr_i    = {5'(a1), 5'(a0)};
    e.a0   = 5'(a0);
    e.a1   = 5'(a1);
    e.d0   = exp_read(r, we, wa, wd, a0);
    e.d1   = exp_read(r, we, wa, wd, a1);
    e.busy = {exp_busy(r, we, wa, a1), exp_busy(r, we, wa, a0)};
    e.cnt  = r ? 6'd0 : 6'(pend_count());
    exp_q.push_back(e);
    // Advance the reference to the state after the coming edge.
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (we && wa != 0) m_pend[wa] = 1'b0;
        if (ie && ia != 0) m_pend[ia] = 1'b1;
      end
    end
  endtask

  task automatic rd(input int a0, input int a1);
    cycle(0, 0, 0, 32'h0, 0, 0, 0, a0, a1);
  endtask

  // Monitor: each half-cycle after stimulus, compare DUT outputs to the head entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rd_data_o[31:0] !== e.d0) begin
          n_bad++;
          $display("FAIL rd0 x%0d @%0t: got %h want %h", e.a0, $time, rd_data_o[31:0], e.d0);
        end
        n_vec++;
        if (rd_data_o[63:32] !== e.d1) begin
          n_bad++;
          $display("FAIL rd1 x%0d @%0t: got %h want %h", e.a1, $time, rd_data_o[63:32], e.d1);
        end
        n_vec++;
        if (rd_busy_o !== e.busy) begin
          n_bad++;
          $display("FAIL busy x%0d/x%0d @%0t: got %b want %b", e.a0, e.a1, $time, rd_busy_o, e.busy);
        end
        n_vec++;
        if (pend_cnt_o !== e.cnt) begin
          n_bad++;
          $display("FAIL pend_cnt @%0t: got %0d want %0d", $time, pend_cnt_o, e.cnt);
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; wr_en_i = 0; wr_addr_i = 0; wr_data_i = 0;
    issue_en_i = 0; issue_addr_i = 0; flush_i = 0; rd_addr_i = 0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end

    // Reset and post-reset reads.
    cycle(1, 0, 0, 32'h0, 0, 0, 0, 5, 31);
    cycle(1, 0, 0, 32'h0, 0, 0, 0, 5, 31);
    rd(5, 31);
    rd(31, 5);
    // Reset asserted during a write: nothing lands.
    cycle(1, 1, 3, 32'hDEADBEEF, 1, 3, 0, 3, 3);
    rd(3, 3);
    // x0 ignores writes; x7 via bypass then storage.
    cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    rd(0, 0);
    cycle(0, 1, 7, 32'h12345678, 0, 0, 0, 0, 7);
    rd(7, 7);
    // Bypass on port 1.
    cycle(0, 1, 9, 32'hA5A5A5A5, 0, 0, 0, 7, 9);
    rd(9, 9);
    // Issue x4, x6; then writeback x4.
    cycle(0, 0, 0, 32'h0, 1, 4, 0, 4, 6);
    cycle(0, 0, 0, 32'h0, 1, 6, 0, 4, 6);
    rd(4, 6);
    cycle(0, 1, 4, 32'h44, 0, 0, 0, 4, 6);
    rd(4, 6);
    // Re-issue and write x8 together; issue x0.
    cycle(0, 0, 0, 32'h0, 1, 8, 0, 8, 6);
    cycle(0, 1, 8, 32'h88, 1, 8, 0, 8, 8);
    rd(8, 8);
    cycle(0, 0, 0, 32'h0, 1, 0, 0, 0, 8);
    rd(0, 8);
    // Pend x1..x3, then flush with issue x10 and write x2.
    cycle(0, 0, 0, 32'h0, 1, 1, 0, 1, 2);
    cycle(0, 0, 0, 32'h0, 1, 2, 0, 1, 2);
    cycle(0, 0, 0, 32'h0, 1, 3, 0, 3, 2);
    rd(1, 3);
    cycle(0, 1, 2, 32'h55, 1, 10, 1, 2, 10);
    rd(2, 10);
    rd(1, 3);

    // Randomized traffic, biased towards low registers for address collisions.
    for (int n = 0; n < 3000; n++) begin
      bit r, we, ie, fl;
      int wa, ia, a0, a1;
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 1) == 1);
      ie = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 19) == 0);
      wa = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      ia = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      a0 = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      cycle(r, we, wa, $urandom, ie, ia, fl, a0, a1);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lx32_regfile_sb.md
Name: lx32_regfile_sb

Overview:
- Parametrised general-purpose register file for the LX32 core, generalising the core's fixed register configuration.
- Adds the following over a plain register array:
  - configurable number of read ports;
  - optional write-to-read bypass;
  - per-register pending-write scoreboard and a pending-register counter.
- Sits between decode/issue (reads, issue marking) and writeback (writes, pending clear).

Parameters:
- XLEN, 32, data width; defaults to lx32_arch_pkg::XLEN.
- REG_COUNT, 32, number of registers (power of two, >=2); defaults to lx32_arch_pkg::REG_COUNT.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value.
- SCOREBOARD, 1, 1 = pending-write tracking enabled; 0 = rd_busy_o and pend_cnt_o tied to 0.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr_i  in  NUM_RD x REG_ADDR_WIDTH  read addresses.
- rd_data_o  out  NUM_RD x XLEN  read data, combinational from rd_addr_i.
- rd_busy_o  out  NUM_RD  register has an outstanding producer, combinational.
- wr_en_i  in  1  writeback valid.
- wr_addr_i  in  REG_ADDR_WIDTH  writeback destination.
- wr_data_i  in  XLEN  writeback data.
- issue_en_i  in  1  instruction issued that will write issue_addr_i.
- issue_addr_i  in  REG_ADDR_WIDTH  destination being marked pending.
- flush_i  in  1  pipeline flush: discard all pending marks.
- pend_cnt_o  out  REG_ADDR_WIDTH+1  number of registers currently pending (registered).

Behaviour:
- Reset (asynchronous, on rst high, regardless of clk):
  - all registers = 0;
  - all pending bits = 0;
  - pend_cnt_o = 0.
  - Outputs follow immediately: rd_data_o = 0 and rd_busy_o = 0 for all ports.
  - Reset asserted mid-operation aborts everything; no write lands in the reset cycle.
- Register x0:
  - reads always return 0 and rd_busy_o = 0;
  - writes to x0 are ignored;
  - issue to x0 never sets pending;
  - x0 is never bypassed.
- Write: on posedge clk with wr_en_i and wr_addr_i != 0, regs[wr_addr_i] <= wr_data_i. Data is visible through storage on the next cycle.
- Read: each port is independent and purely combinational. Multiple ports reading the same address return identical data.
- Bypass (BYPASS=1): if wr_en_i && wr_addr_i == rd_addr_i[k] && rd_addr_i[k] != 0, then rd_data_o[k] = wr_data_i in the same cycle.
- Scoreboard (SCOREBOARD=1), with pending vector pend[REG_COUNT-1:0] updated per posedge in this priority:
  1. flush_i: pend <= 0 for all registers, including a same-cycle issue (flush kills the issuing op). A same-cycle write still updates data.
  2. Otherwise, issue_en_i to register r (r != 0): pend[r] <= 1. If a writeback to the same r occurs in the same cycle, pend[r] stays 1 (a new producer supersedes the old one).
  3. Otherwise, wr_en_i to register r: pend[r] <= 0.
  - Issue and writeback to different registers in the same cycle both take effect.
- rd_busy_o[k]:
  - equals pend[rd_addr_i[k]];
  - with BYPASS=1, forced to 0 when the same-cycle write to that address is present (data available);
  - always 0 for x0.
- pend_cnt_o:
  - registered population count of pend, updated incrementally each cycle by +1, -1, 0 or reset to 0 on flush;
  - range 0..REG_COUNT-1, and it never wraps;
  - re-issue of an already pending register and writeback of a non-pending register leave the count unchanged.
- Latency:
  - read: 0 cycles;
  - write to storage read: 1 cycle;
  - issue to busy: 1 cycle.

Decomposition:
- lx32_arch_pkg gains:
  - NUM_RD_DEFAULT;
  - typedef pend_vec_t (logic [REG_COUNT-1:0]);
  - typedef pend_cnt_t (logic [REG_ADDR_WIDTH:0]).
- reg_idx_t and data_t are reused for addresses and data.
- One sub-module is natural: lx32_scoreboard, which holds the pend vector, the flush/issue/writeback priority and pend_cnt_o. lx32_regfile_sb instantiates it under a SCOREBOARD generate.

Test Plan:
- Reset then read x5, x31 on both ports -> 0, busy 0, pend_cnt_o 0. Assert rst mid-write of x3=0xDEADBEEF -> x3 reads 0 afterwards.
- Write x0=0xFFFFFFFF, then x7=0x12345678 -> x0 reads 0; next cycle both ports reading x7 return 0x12345678.
- BYPASS=1: write x9=0xA5A5A5A5 while port1 reads x9 -> rd_data_o[1]=0xA5A5A5A5 in the same cycle. BYPASS=0 -> old value 0 that cycle, new value next cycle.
- Issue x4, x6 on consecutive cycles -> busy on x4/x6 and pend_cnt_o=2. Writeback x4 -> x4 busy 0 (same cycle with bypass), pend_cnt_o=1.
- Same cycle issue x8 and write x8 after an earlier issue of x8 -> pend[8] stays 1 and pend_cnt_o unchanged. Issue x0 -> pend_cnt_o unchanged.
- Pend x1..x3, then flush_i with simultaneous issue x10 and write x2=0x55 -> all busy 0, pend_cnt_o=0, x2 reads 0x55.
